// File: rtl/reg_rename_file_pkg.sv
// Shared widths for the rename register file; one-cycle update, no backpressure.
// Optional commit forwarding lives in reg_operand_read under REGFILE_COMMIT_FWD_EN.
package reg_rename_file_pkg;
  localparam int DEF_ROB_BIT = 3;
  localparam int DEF_REG_NUM = 32;
  localparam int REG_BIT     = 5;
  localparam int ROB_SIZE    = 1 << DEF_ROB_BIT;
  localparam int XLEN        = 32;
endpackage

// File: rtl/reg_rename_file_if.sv
// Issue/commit/operand-lookup bundle between the regfile (slave) and decoder/ROB (master).
// Purely combinational wires; no handshake, the pause is the separate rdy_in pin.
interface reg_rename_file_if
  import reg_rename_file_pkg::*;
#(
  parameter int ROB_BIT = DEF_ROB_BIT
);
  logic               issue_pollute;
  logic [REG_BIT-1:0] issue_reg_id;
  logic [ROB_BIT-1:0] issue_rob_entry;

  logic               rob_commit;
  logic [REG_BIT-1:0] commit_rd_reg_id;
  logic [ROB_BIT-1:0] commit_rob_entry;
  logic [XLEN-1:0]    commit_value;

  logic [REG_BIT-1:0] rs1_id;
  logic [REG_BIT-1:0] rs2_id;
  logic               rs1_ready;
  logic               rs2_ready;
  logic [XLEN-1:0]    rs1_value;
  logic [XLEN-1:0]    rs2_value;
  logic [ROB_BIT-1:0] rs1_rob_entry;
  logic [ROB_BIT-1:0] rs2_rob_entry;

  logic [ROB_BIT-1:0] get_rob_entry1;
  logic [ROB_BIT-1:0] get_rob_entry2;
  logic               rob_ready1;
  logic               rob_ready2;
  logic [XLEN-1:0]    rob_value1;
  logic [XLEN-1:0]    rob_value2;

  modport slave (
    input  issue_pollute, issue_reg_id, issue_rob_entry,
    input  rob_commit, commit_rd_reg_id, commit_rob_entry, commit_value,
    input  rs1_id, rs2_id, rob_ready1, rob_ready2, rob_value1, rob_value2,
    output rs1_ready, rs2_ready, rs1_value, rs2_value, rs1_rob_entry, rs2_rob_entry,
    output get_rob_entry1, get_rob_entry2
  );

  modport master (
    output issue_pollute, issue_reg_id, issue_rob_entry,
    output rob_commit, commit_rd_reg_id, commit_rob_entry, commit_value,
    output rs1_id, rs2_id, rob_ready1, rob_ready2, rob_value1, rob_value2,
    input  rs1_ready, rs2_ready, rs1_value, rs2_value, rs1_rob_entry, rs2_rob_entry,
    input  get_rob_entry1, get_rob_entry2
  );
endinterface

// File: rtl/reg_rename_file_operand_read.sv
// One operand read port: x0 / clean value / commit bypass / ROB lookup, in that priority.
// Zero latency (pure combinational), no backpressure; bypass only with REGFILE_COMMIT_FWD_EN.
module reg_operand_read
  import reg_rename_file_pkg::*;
#(
  parameter int ROB_BIT = DEF_ROB_BIT
) (
  input  logic [REG_BIT-1:0] rd_id,
  input  logic               is_busy,
  input  logic [ROB_BIT-1:0] rd_tag,
  input  logic [XLEN-1:0]    rd_val,
  input  logic               rob_ready,
  input  logic [XLEN-1:0]    rob_value,
`ifdef REGFILE_COMMIT_FWD_EN
  input  logic               commit_vld,
  input  logic [REG_BIT-1:0] commit_rd,
  input  logic [ROB_BIT-1:0] commit_entry,
  input  logic [XLEN-1:0]    commit_value,
`endif
  output logic               ready,
  output logic [XLEN-1:0]    value,
  output logic [ROB_BIT-1:0] rob_entry,
  output logic [ROB_BIT-1:0] get_rob_entry
);
  always_comb begin
    ready         = 1'b0;
    value         = '0;
    rob_entry     = '0;
    get_rob_entry = (rd_id == '0) ? '0 : rd_tag;
    if (rd_id == '0) begin
      ready = 1'b1;
    end else if (!is_busy) begin
      ready = 1'b1;
      value = rd_val;
    end
`ifdef REGFILE_COMMIT_FWD_EN
    // Producer retiring this very cycle: take its value before it lands in the array.
    else if (commit_vld && commit_rd == rd_id && commit_entry == rd_tag) begin
      ready = 1'b1;
      value = commit_value;
    end
`endif
    else if (rob_ready) begin
      ready = 1'b1;
      value = rob_value;
    end else begin
      rob_entry = rd_tag;
    end
  end
endmodule

// File: rtl/reg_rename_file.sv
// Architectural regfile with ROB rename tags; updates land one edge later, rdy_in low freezes state.
// REGFILE_COMMIT_FWD_EN enables same-cycle commit bypass on the two read ports.
module reg_rename_file
  import reg_rename_file_pkg::*;
#(
  parameter int ROB_BIT = DEF_ROB_BIT,
  parameter int REG_NUM = DEF_REG_NUM
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                clear_up,
  reg_rename_file_if.slave    bus
);
  logic [XLEN-1:0]    val_q  [REG_NUM];
  logic               busy_q [REG_NUM];
  logic [ROB_BIT-1:0] tag_q  [REG_NUM];

  logic issue_en;
  logic commit_en;
  logic commit_clr;

  // A flush discards any rename issued in the same cycle.
  assign issue_en   = rdy_in && bus.issue_pollute && (bus.issue_reg_id != '0) && !clear_up;
  assign commit_en  = rdy_in && bus.rob_commit && (bus.commit_rd_reg_id != '0);
  assign commit_clr = commit_en
                   && (tag_q[bus.commit_rd_reg_id] == bus.commit_rob_entry)
                   && !(bus.issue_pollute && bus.issue_reg_id == bus.commit_rd_reg_id);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < REG_NUM; i++) begin
        val_q[i]  <= '0;
        busy_q[i] <= 1'b0;
        tag_q[i]  <= '0;
      end
    end else if (rdy_in) begin
      if (commit_en) begin
        val_q[bus.commit_rd_reg_id] <= bus.commit_value;
        if (commit_clr) busy_q[bus.commit_rd_reg_id] <= 1'b0;
      end
      if (issue_en) begin
        busy_q[bus.issue_reg_id] <= 1'b1;
        tag_q[bus.issue_reg_id]  <= bus.issue_rob_entry;
      end
      if (clear_up) begin
        for (int i = 0; i < REG_NUM; i++) busy_q[i] <= 1'b0;
      end
    end
  end

  reg_operand_read #(.ROB_BIT(ROB_BIT)) u_read1 (
    .rd_id         (bus.rs1_id),
    .is_busy       (busy_q[bus.rs1_id]),
    .rd_tag        (tag_q[bus.rs1_id]),
    .rd_val        (val_q[bus.rs1_id]),
    .rob_ready     (bus.rob_ready1),
    .rob_value     (bus.rob_value1),
`ifdef REGFILE_COMMIT_FWD_EN
    .commit_vld    (bus.rob_commit),
    .commit_rd     (bus.commit_rd_reg_id),
    .commit_entry  (bus.commit_rob_entry),
    .commit_value  (bus.commit_value),
`endif
    .ready         (bus.rs1_ready),
    .value         (bus.rs1_value),
    .rob_entry     (bus.rs1_rob_entry),
    .get_rob_entry (bus.get_rob_entry1)
  );

  reg_operand_read #(.ROB_BIT(ROB_BIT)) u_read2 (
    .rd_id         (bus.rs2_id),
    .is_busy       (busy_q[bus.rs2_id]),
    .rd_tag        (tag_q[bus.rs2_id]),
    .rd_val        (val_q[bus.rs2_id]),
    .rob_ready     (bus.rob_ready2),
    .rob_value     (bus.rob_value2),
`ifdef REGFILE_COMMIT_FWD_EN
    .commit_vld    (bus.rob_commit),
    .commit_rd     (bus.commit_rd_reg_id),
    .commit_entry  (bus.commit_rob_entry),
    .commit_value  (bus.commit_value),
`endif
    .ready         (bus.rs2_ready),
    .value         (bus.rs2_value),
    .rob_entry     (bus.rs2_rob_entry),
    .get_rob_entry (bus.get_rob_entry2)
  );
endmodule

// File: tb/tb_reg_rename_file.sv
// Table-driven bench for reg_rename_file: each row drives one cycle of stimulus and
// checks the combinational read ports against expectations queued when the row is driven.
module tb_reg_rename_file;
  import reg_rename_file_pkg::*;

`ifdef REGFILE_COMMIT_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic       rdy;
    logic       clr;
    logic       iss;
    logic [4:0] ird;
    logic [2:0] ie;
    logic       cmt;
    logic [4:0] crd;
    logic [2:0] ce;
    logic [31:0] cv;
  } ctl_t;

  typedef struct packed {
    logic [4:0]  rs1;
    logic        rr1;
    logic [31:0] rv1;
    logic [4:0]  rs2;
    logic        rr2;
    logic [31:0] rv2;
  } rd_t;

  typedef struct packed {
    logic        r1;
    logic [31:0] v1;
    logic [2:0]  e1;
    logic [2:0]  g1;
    logic        r2;
    logic [31:0] v2;
    logic [2:0]  e2;
    logic [2:0]  g2;
  } ex_t;

  typedef struct packed {
    ctl_t c;
    rd_t  r;
    ex_t  x;
  } vec_t;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic clear_up;

  reg_rename_file_if #(.ROB_BIT(3)) bus ();

  reg_rename_file #(.ROB_BIT(3), .REG_NUM(32)) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .clear_up (clear_up),
    .bus      (bus)
  );

  always #5 clk_in = ~clk_in;

  int   tests = 0;
  int   fails = 0;
  vec_t vecs[$];
  ex_t  sb_q[$];

  function automatic ctl_t c_(int rdy, int clr, int iss, int ird, int ie,
                              int cmt, int crd, int ce, int cv);
    ctl_t c;
    c.rdy = 1'(rdy); c.clr = 1'(clr); c.iss = 1'(iss); c.ird = 5'(ird); c.ie = 3'(ie);
    c.cmt = 1'(cmt); c.crd = 5'(crd); c.ce = 3'(ce); c.cv = 32'(cv);
    return c;
  endfunction

  function automatic rd_t r_(int rs1, int rr1, int rv1, int rs2, int rr2, int rv2);
    rd_t r;
    r.rs1 = 5'(rs1); r.rr1 = 1'(rr1); r.rv1 = 32'(rv1);
    r.rs2 = 5'(rs2); r.rr2 = 1'(rr2); r.rv2 = 32'(rv2);
    return r;
  endfunction

  function automatic ex_t x_(int r1, int v1, int e1, int g1, int r2, int v2, int e2, int g2);
    ex_t x;
    x.r1 = 1'(r1); x.v1 = 32'(v1); x.e1 = 3'(e1); x.g1 = 3'(g1);
    x.r2 = 1'(r2); x.v2 = 32'(v2); x.e2 = 3'(e2); x.g2 = 3'(g2);
    return x;
  endfunction

  task automatic drive(input vec_t v);
    rdy_in               = v.c.rdy;
    clear_up             = v.c.clr;
    bus.issue_pollute    = v.c.iss;
    bus.issue_reg_id     = v.c.ird;
    bus.issue_rob_entry  = v.c.ie;
    bus.rob_commit       = v.c.cmt;
    bus.commit_rd_reg_id = v.c.crd;
    bus.commit_rob_entry = v.c.ce;
    bus.commit_value     = v.c.cv;
    bus.rs1_id           = v.r.rs1;
    bus.rob_ready1       = v.r.rr1;
    bus.rob_value1       = v.r.rv1;
    bus.rs2_id           = v.r.rs2;
    bus.rob_ready2       = v.r.rr2;
    bus.rob_value2       = v.r.rv2;
  endtask

  task automatic check(input string name);
    ex_t act;
    ex_t exp;
    tests++;
    act = {bus.rs1_ready, bus.rs1_value, bus.rs1_rob_entry, bus.get_rob_entry1,
           bus.rs2_ready, bus.rs2_value, bus.rs2_rob_entry, bus.get_rob_entry2};
    if (sb_q.size() == 0) begin
      fails++;
      $display("FAIL %s: scoreboard empty, got r1=%0b v1=%h", name, act.r1, act.v1);
    end else begin
      exp = sb_q.pop_front();
      if (act !== exp) begin
        fails++;
        $display("FAIL %s: got r1=%0b v1=%h e1=%0d g1=%0d r2=%0b v2=%h e2=%0d g2=%0d, want r1=%0b v1=%h e1=%0d g1=%0d r2=%0b v2=%h e2=%0d g2=%0d",
                 name, act.r1, act.v1, act.e1, act.g1, act.r2, act.v2, act.e2, act.g2,
                 exp.r1, exp.v1, exp.e1, exp.g1, exp.r2, exp.v2, exp.e2, exp.g2);
      end
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    @(negedge clk_in);
    drive(v);
    sb_q.push_back(v.x);
    #1;
    check(name);
  endtask

  initial begin
    ctl_t idle;
    rd_t  r0;
    ex_t  xclean;
    idle   = c_(1, 0, 0, 0, 0, 0, 0, 0, 0);
    r0     = r_(0, 0, 0, 0, 0, 0);
    xclean = x_(1, 0, 0, 0, 1, 0, 0, 0);

    // rows: ctl(rdy,clr,iss,ird,ie,cmt,crd,ce,cv) / reads(rs1,rr1,rv1,rs2,rr2,rv2) / expected
    vecs.push_back('{c_(1,0,1,5,3,0,0,0,0),       r_(5,0,0,0,0,0),               x_(1,0,0,0,1,0,0,0)});
    vecs.push_back('{idle,                        r_(5,0,'h9999,5,1,'h1234),     x_(0,0,3,3,1,'h1234,0,3)});
    vecs.push_back('{c_(1,0,1,5,4,1,5,3,'hAA),    r_(5,0,0,0,0,0),
                     FWD ? x_(1,'hAA,0,3,1,0,0,0) : x_(0,0,3,3,1,0,0,0)});
    vecs.push_back('{c_(1,0,0,0,0,1,5,3,'hBB),    r_(5,0,0,0,0,0),               x_(0,0,4,4,1,0,0,0)});
    vecs.push_back('{idle,                        r_(5,0,0,0,0,0),               x_(0,0,4,4,1,0,0,0)});
    vecs.push_back('{c_(1,0,0,0,0,1,5,4,'hCC),    r_(5,1,'hCC,0,0,0),            x_(1,'hCC,0,4,1,0,0,0)});
    vecs.push_back('{idle,                        r_(5,0,0,6,0,0),               x_(1,'hCC,0,4,1,0,0,0)});
    vecs.push_back('{c_(1,0,0,0,0,1,7,1,'h77),    r0,                            xclean});
    vecs.push_back('{c_(1,0,1,6,5,0,0,0,0),       r0,                            xclean});
    vecs.push_back('{c_(1,1,1,7,2,1,6,0,'h55),    r_(7,0,0,6,0,0),               x_(1,'h77,0,0,0,0,5,5)});
    vecs.push_back('{idle,                        r_(6,0,0,7,0,0),               x_(1,'h55,0,5,1,'h77,0,0)});
    vecs.push_back('{c_(1,0,1,0,6,1,0,0,'hFFFF),  r0,                            xclean});
    vecs.push_back('{idle,                        r_(0,1,'hDEAD,0,1,'hBEEF),     xclean});
    vecs.push_back('{c_(0,0,1,9,1,1,9,0,7),       r_(9,0,0,0,0,0),               xclean});
    vecs.push_back('{idle,                        r_(9,0,0,0,0,0),               xclean});
    vecs.push_back('{c_(1,0,1,9,1,0,0,0,0),       r0,                            xclean});
    vecs.push_back('{c_(1,0,0,0,0,1,9,1,7),       r_(9,0,0,9,1,7),
                     FWD ? x_(1,7,0,1,1,7,0,1) : x_(0,0,1,1,1,7,0,1)});
    vecs.push_back('{idle,                        r_(9,0,0,0,0,0),               x_(1,7,0,1,1,0,0,0)});
    vecs.push_back('{c_(1,0,1,10,2,0,0,0,0),      r0,                            xclean});
    vecs.push_back('{c_(0,1,0,0,0,0,0,0,0),       r_(10,0,0,0,0,0),              x_(0,0,2,2,1,0,0,0)});
    vecs.push_back('{idle,                        r_(10,0,0,0,0,0),              x_(0,0,2,2,1,0,0,0)});
    vecs.push_back('{c_(1,1,0,0,0,0,0,0,0),       r_(10,0,0,0,0,0),              x_(0,0,2,2,1,0,0,0)});
    vecs.push_back('{idle,                        r_(10,0,0,0,0,0),              x_(1,0,0,2,1,0,0,0)});
    vecs.push_back('{c_(1,0,1,11,3,0,0,0,0),      r0,                            xclean});

    rst_in = 1'b1;
    drive('{idle, r0, xclean});
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Reset must win over a paused pipeline and wipe values, busy bits and tags.
    @(negedge clk_in);
    drive('{c_(0,0,1,12,5,1,5,0,'h1111), r0, xclean});
    rst_in = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    apply('{idle, r_(5,0,0,11,0,0), xclean}, "reset_over_pause");
    apply('{idle, r_(12,0,0,10,0,0), xclean}, "reset_tags");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
